pc_redirect_unit: RTL and testbench

PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

---
 rtl/pc_redirect_unit.sv | 120 ++++++++++++
 tb/tb_pc_redirect_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with prioritised redirect sources and an optional
// one-entry buffer for redirects arriving while stalled (macro PC_PENDING_EN).
module pc_redirect_unit #(
    parameter int unsigned          PC_WIDTH = 16,
    parameter int unsigned          PC_INC   = 1,
    parameter int unsigned          NUM_SRC  = 3,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC*PC_WIDTH-1:0] src_pc,
    output logic [PC_WIDTH-1:0]         pc,
    output logic [PC_WIDTH-1:0]         pc_plus,
    output logic                        redirect_taken,
    output logic                        pending
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                rt_q, rt_d;
    logic                live_vld;
    logic [PC_WIDTH-1:0] live_pc;

    assign pc_plus        = pc_q + PC_WIDTH'(PC_INC);
    assign pc             = pc_q;
    assign redirect_taken = rt_q;

`ifdef PC_PENDING_EN
    logic                pend_q, pend_d;
    logic [IDX_W-1:0]    pidx_q, pidx_d;
    logic [PC_WIDTH-1:0] ppc_q, ppc_d;
    logic [IDX_W-1:0]    live_idx;
    logic                live_wins;

    assign pending = pend_q;
`else
    assign pending = 1'b0;
`endif

    // Lowest-index valid source wins; the rest are dropped this cycle.
    always_comb begin
        live_vld = 1'b0;
        live_pc  = '0;
`ifdef PC_PENDING_EN
        live_idx = '0;
`endif
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (src_valid[i] && !live_vld) begin
                live_vld = 1'b1;
                live_pc  = src_pc[i*PC_WIDTH +: PC_WIDTH];
`ifdef PC_PENDING_EN
                live_idx = IDX_W'(i);
`endif
            end
        end
    end

    always_comb begin
        pc_d = pc_q;
        rt_d = 1'b0;
`ifdef PC_PENDING_EN
        pend_d    = pend_q;
        pidx_d    = pidx_q;
        ppc_d     = ppc_q;
        // Equal index favours the newer request over the buffered one.
        live_wins = live_vld && (!pend_q || (live_idx <= pidx_q));
        if (stall) begin
            if (live_wins) begin
                pend_d = 1'b1;
                pidx_d = live_idx;
                ppc_d  = live_pc;
            end
        end else begin
            pend_d = 1'b0;
            if (live_wins) begin
                pc_d = live_pc;
                rt_d = 1'b1;
            end else if (pend_q) begin
                pc_d = ppc_q;
                rt_d = 1'b1;
            end else begin
                pc_d = pc_plus;
            end
        end
`else
        if (!stall) begin
            if (live_vld) begin
                pc_d = live_pc;
                rt_d = 1'b1;
            end else begin
                pc_d = pc_plus;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
            rt_q <= 1'b0;
`ifdef PC_PENDING_EN
            pend_q <= 1'b0;
            pidx_q <= '0;
            ppc_q  <= '0;
`endif
        end else begin
            pc_q <= pc_d;
            rt_q <= rt_d;
`ifdef PC_PENDING_EN
            pend_q <= pend_d;
            pidx_q <= pidx_d;
            ppc_q  <= ppc_d;
`endif
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed scenarios plus random
// traffic against a rule-level reference model (honours PC_PENDING_EN).
module tb_pc_redirect_unit;

    localparam int W = 16;
    localparam int N = 3;
    localparam int MOD = 1 << W;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic [N-1:0]     src_valid;
    logic [N*W-1:0]   src_pc;
    logic [W-1:0]     pc;
    logic [W-1:0]     pc_plus;
    logic             redirect_taken;
    logic             pending;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef PC_PENDING_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    // Reference model state
    int unsigned m_pc;
    bit          m_rt;
    bit          m_pend;
    int unsigned m_ptgt;
    int          m_pidx;

    always #5 clk = ~clk;

    pc_redirect_unit #(
        .PC_WIDTH (W),
        .PC_INC   (1),
        .NUM_SRC  (N),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .src_valid      (src_valid),
        .src_pc         (src_pc),
        .pc             (pc),
        .pc_plus        (pc_plus),
        .redirect_taken (redirect_taken),
        .pending        (pending)
    );

    task automatic model_step();
        int win;
        int unsigned tgt;
        win = -1;
        tgt = 0;
        for (int i = 0; i < N; i++) begin
            if (src_valid[i] && win < 0) begin
                win = i;
                tgt = src_pc[i*W +: W];
            end
        end
        if (rst) begin
            m_pc = 0; m_rt = 0; m_pend = 0; m_ptgt = 0; m_pidx = 0;
        end else if (stall) begin
            m_rt = 0;
            if (PEN && win >= 0 && (!m_pend || win <= m_pidx)) begin
                m_pend = 1; m_ptgt = tgt; m_pidx = win;
            end
        end else begin
            if (win >= 0 && (!m_pend || win <= m_pidx)) begin
                m_pc = tgt; m_rt = 1;
            end else if (m_pend) begin
                m_pc = m_ptgt; m_rt = 1;
            end else begin
                m_pc = (m_pc + 1) % MOD; m_rt = 0;
            end
            m_pend = 0;
        end
    endtask

    // Apply one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic tick(input bit st, input logic [N-1:0] v,
                        input logic [W-1:0] p0, input logic [W-1:0] p1,
                        input logic [W-1:0] p2);
        stall     = st;
        src_valid = v;
        src_pc    = {p2, p1, p0};
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1'b1, 3'b111, 16'h1234, 16'h5678, 16'h9abc);
        tick(1'b0, 3'b010, 16'h1111, 16'h2222, 16'h3333);
        n_checks++;
        if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got %h want 0000", pc); end
        n_checks++;
        if (redirect_taken !== 1'b0 || pending !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got rt=%b pend=%b want 0 0", redirect_taken, pending);
        end
        n_checks++;
        if (pc_plus !== 16'h0001) begin n_fail++; $display("FAIL reset_pc_plus got %h want 0001", pc_plus); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 4; i++) begin
            tick(1'b0, 3'b000, 16'h0, 16'h0, 16'h0);
            n_checks++;
            if (pc !== W'(i) || redirect_taken !== 1'b0) begin
                n_fail++; $display("FAIL seq_%0d got pc=%h rt=%b want pc=%h rt=0", i, pc, redirect_taken, W'(i));
            end
        end
    endtask

    task automatic test_priority();
        tick(1'b0, 3'b001, 16'h0010, 16'h0, 16'h0);
        tick(1'b0, 3'b110, 16'h0, 16'h0200, 16'h0300);
        n_checks++;
        if (pc !== 16'h0200 || redirect_taken !== 1'b1) begin
            n_fail++; $display("FAIL priority got pc=%h rt=%b want 0200 1", pc, redirect_taken);
        end
        tick(1'b0, 3'b000, 16'h0, 16'h0, 16'h0);
        n_checks++;
        if (pc !== 16'h0201 || redirect_taken !== 1'b0) begin
            n_fail++; $display("FAIL priority_after got pc=%h rt=%b want 0201 0", pc, redirect_taken);
        end
    endtask

    task automatic test_stall_pending();
        tick(1'b1, 3'b100, 16'h0, 16'h0, 16'h0300);
        n_checks++;
        if (pc !== 16'h0201 || pending !== PEN || redirect_taken !== 1'b0) begin
            n_fail++; $display("FAIL stall_a got pc=%h pend=%b rt=%b want 0201 %b 0", pc, pending, redirect_taken, PEN);
        end
        tick(1'b1, 3'b001, 16'h0400, 16'h0, 16'h0);
        n_checks++;
        if (pc !== 16'h0201 || pending !== PEN) begin
            n_fail++; $display("FAIL stall_b got pc=%h pend=%b want 0201 %b", pc, pending, PEN);
        end
        tick(1'b0, 3'b000, 16'h0, 16'h0, 16'h0);
        n_checks++;
        if (pc !== (PEN ? 16'h0400 : 16'h0202) || pending !== 1'b0 || redirect_taken !== PEN) begin
            n_fail++; $display("FAIL stall_release got pc=%h pend=%b rt=%b want %h 0 %b",
                               pc, pending, redirect_taken, PEN ? 16'h0400 : 16'h0202, PEN);
        end
        // Buffered src0 must beat a lower-priority live src1 on release.
        tick(1'b1, 3'b001, 16'h0400, 16'h0, 16'h0);
        tick(1'b0, 3'b010, 16'h0, 16'h0500, 16'h0);
        n_checks++;
        if (pc !== (PEN ? 16'h0400 : 16'h0500) || pending !== 1'b0 || redirect_taken !== 1'b1) begin
            n_fail++; $display("FAIL buffered_wins got pc=%h pend=%b rt=%b want %h 0 1",
                               pc, pending, redirect_taken, PEN ? 16'h0400 : 16'h0500);
        end
    endtask

    task automatic test_wrap();
        tick(1'b0, 3'b001, 16'hFFFF, 16'h0, 16'h0);
        n_checks++;
        if (pc !== 16'hFFFF || pc_plus !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_edge got pc=%h pc_plus=%h want ffff 0000", pc, pc_plus);
        end
        tick(1'b0, 3'b000, 16'h0, 16'h0, 16'h0);
        n_checks++;
        if (pc !== 16'h0000 || pc_plus !== 16'h0001 || redirect_taken !== 1'b0) begin
            n_fail++; $display("FAIL wrap got pc=%h pc_plus=%h rt=%b want 0000 0001 0", pc, pc_plus, redirect_taken);
        end
    endtask

    task automatic test_reset_mid_stall();
        tick(1'b0, 3'b001, 16'h0010, 16'h0, 16'h0);
        tick(1'b1, 3'b001, 16'h0400, 16'h0, 16'h0);
        rst = 1'b1;
        tick(1'b1, 3'b011, 16'h0700, 16'h0800, 16'h0);
        n_checks++;
        if (pc !== 16'h0000 || pending !== 1'b0 || redirect_taken !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_stall got pc=%h pend=%b rt=%b want 0000 0 0", pc, pending, redirect_taken);
        end
        rst = 1'b0;
        tick(1'b0, 3'b000, 16'h0, 16'h0, 16'h0);
        n_checks++;
        if (pc !== 16'h0001 || pending !== 1'b0 || redirect_taken !== 1'b0) begin
            n_fail++; $display("FAIL rst_release got pc=%h pend=%b rt=%b want 0001 0 0", pc, pending, redirect_taken);
        end
        tick(1'b0, 3'b001, 16'h0010, 16'h0, 16'h0);
        tick(1'b1, 3'b100, 16'h0, 16'h0, 16'h0300);
        tick(1'b1, 3'b001, 16'h0400, 16'h0, 16'h0);
        tick(1'b0, 3'b000, 16'h0, 16'h0, 16'h0);
        n_checks++;
        if (pc !== (PEN ? 16'h0400 : 16'h0011)) begin
            n_fail++; $display("FAIL stall_repeat got pc=%h want %h", pc, PEN ? 16'h0400 : 16'h0011);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] t;
        for (int i = 0; i < 3; i++) begin
            t = W'($urandom_range(0, MOD - 1));
            tick(1'b0, 3'b100 >> i, t, t, t);
            n_checks++;
            if (pc !== t || redirect_taken !== 1'b1) begin
                n_fail++; $display("FAIL b2b_%0d got pc=%h rt=%b want %h 1", i, pc, redirect_taken, t);
            end
        end
        tick(1'b0, 3'b000, 16'h0, 16'h0, 16'h0);
        n_checks++;
        if (redirect_taken !== 1'b0 || pc !== t + 16'd1) begin
            n_fail++; $display("FAIL b2b_end got pc=%h rt=%b want %h 0", pc, redirect_taken, t + 16'd1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            tick($urandom_range(0, 2) == 0, N'($urandom_range(0, 7) & $urandom_range(0, 7)),
                 W'($urandom_range(0, MOD - 1)), W'($urandom_range(0, MOD - 1)),
                 W'($urandom_range(0, MOD - 1)));
            n_checks++;
            if (pc !== W'(m_pc) || pc_plus !== W'((m_pc + 1) % MOD) ||
                redirect_taken !== m_rt || pending !== m_pend) begin
                n_fail++;
                $display("FAIL random_%0d got pc=%h pp=%h rt=%b pend=%b want %h %h %b %b", i,
                         pc, pc_plus, redirect_taken, pending, W'(m_pc), W'((m_pc + 1) % MOD), m_rt, m_pend);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        stall     = 1'b0;
        src_valid = '0;
        src_pc    = '0;
        m_pc = 0; m_rt = 0; m_pend = 0; m_ptgt = 0; m_pidx = 0;
        test_reset();
        test_sequential();
        test_priority();
        test_stall_pending();
        test_wrap();
        test_reset_mid_stall();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
